memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller_pkg.sv | 27 ++
 rtl/memory_controller_priority_encoder.sv | 26 ++
 rtl/memory_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_memory_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_pkg.sv
// Shared types for the key/value memory controller: request ops, response
// status codes and controller FSM states.
package memory_pkg;

   typedef enum logic [1:0] {
      OP_GET  = 2'd0,
      OP_PUT  = 2'd1,
      OP_DEL  = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_MISS = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WRITE  = 3'd2,
      S_READ   = 3'd3,
      S_RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/memory_controller_priority_encoder.sv
// Lowest-set-bit encoder with a found flag; used for both the hit search and
// the free-slot search of the controller.
module priority_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] bits,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // scan upward so the first set bit wins
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bits[i] && !found) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/memory_controller.sv
// Small fully-associative key/value cache controller: keys and valid bits are
// held here, values live in external per-slot register arrays on a shared bus.
module memory_controller
   import memory_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = 16,
   parameter int VALUE_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [1:0]                         req_op,
   input  logic [KEY_WIDTH-1:0]               req_key,
   input  logic [VALUE_WIDTH-1:0]             req_value,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [1:0]                         resp_status,
   output logic [VALUE_WIDTH-1:0]             resp_value,
   output logic [NUM_ENTRIES-1:0]             write_op,
   output logic [NUM_ENTRIES-1:0]             select_op,
   output logic [VALUE_WIDTH-1:0]             wr_data,
   input  logic [VALUE_WIDTH-1:0]             rd_data,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

   function automatic logic [OCC_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
      logic [OCC_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         c = c + OCC_W'(v[i]);
      end
      return c;
   endfunction

   state_e                   state_r, state_s;
   op_e                      cap_op_r;
   logic [KEY_WIDTH-1:0]     cap_key_r;
   logic [VALUE_WIDTH-1:0]   cap_value_r;
   logic [NUM_ENTRIES-1:0]   valid_r, valid_s;
   logic [KEY_WIDTH-1:0]     key_r [NUM_ENTRIES];
   logic [IDX_W-1:0]         tgt_idx_r, tgt_idx_s;
   logic [NUM_ENTRIES-1:0]   hit_vec_s, free_vec_s;
   logic [IDX_W-1:0]         hit_idx_s, free_idx_s;
   logic                     hit_found_s, free_found_s;
   status_e                  lkp_status_s;
   logic                     accept_s;

   logic                     req_ready_r;
   logic                     resp_valid_r;
   status_e                  resp_status_r, resp_status_s;
   logic [VALUE_WIDTH-1:0]   resp_value_r, resp_value_s;
   logic [NUM_ENTRIES-1:0]   write_op_r, write_op_s;
   logic [NUM_ENTRIES-1:0]   select_op_r, select_op_s;
   logic [VALUE_WIDTH-1:0]   wr_data_r, wr_data_s;
   logic [OCC_W-1:0]         occupancy_r;

   assign accept_s   = (state_r == S_IDLE) && req_ready_r && req_valid;
   assign free_vec_s = ~valid_r;

   // key match against every valid slot
   always_comb begin
      hit_vec_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         hit_vec_s[i] = valid_r[i] && (key_r[i] == cap_key_r);
      end
   end

   priority_encoder #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_hit_enc (
      .bits  (hit_vec_s),
      .idx   (hit_idx_s),
      .found (hit_found_s)
   );

   priority_encoder #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_enc (
      .bits  (free_vec_s),
      .idx   (free_idx_s),
      .found (free_found_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state, lookup outcome and target slot
   always_comb begin
      state_s      = state_r;
      lkp_status_s = ST_OK;
      tgt_idx_s    = hit_idx_s;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_s = S_LOOKUP;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOOKUP: begin
            case (cap_op_r)
               OP_GET: begin
                  if (hit_found_s) begin
                     state_s = S_READ;
                  end else begin
                     state_s      = S_RESP;
                     lkp_status_s = ST_MISS;
                  end
               end
               OP_PUT: begin
                  if (hit_found_s) begin
                     state_s = S_WRITE;
                  end else if (free_found_s) begin
                     state_s   = S_WRITE;
                     tgt_idx_s = free_idx_s;
                  end else begin
                     state_s      = S_RESP;
                     lkp_status_s = ST_FULL;
                  end
               end
               OP_DEL: begin
                  state_s = S_RESP;
                  if (hit_found_s) begin
                     lkp_status_s = ST_OK;
                  end else begin
                     lkp_status_s = ST_MISS;
                  end
               end
               default: begin
                  state_s      = S_RESP;
                  lkp_status_s = ST_ERR;
               end
            endcase
         end
         S_WRITE, S_READ: begin
            state_s = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_RESP;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // FSM outputs: next values of strobes, response and slot valid bits
   always_comb begin
      valid_s       = valid_r;
      write_op_s    = '0;
      select_op_s   = '0;
      wr_data_s     = '0;
      resp_status_s = resp_status_r;
      resp_value_s  = '0;
      if (state_s == S_WRITE) begin
         write_op_s[tgt_idx_s] = 1'b1;
         wr_data_s             = cap_value_r;
      end else if (state_s == S_READ) begin
         select_op_s[tgt_idx_s] = 1'b1;
      end else begin
         write_op_s = '0;
      end
      case (state_r)
         S_LOOKUP: begin
            resp_status_s = lkp_status_s;
            if ((cap_op_r == OP_DEL) && hit_found_s) begin
               valid_s[hit_idx_s] = 1'b0;
            end else begin
               valid_s = valid_r;
            end
         end
         S_WRITE: begin
            valid_s[tgt_idx_r] = 1'b1;
            resp_status_s      = ST_OK;
         end
         S_READ: begin
            resp_status_s = ST_OK;
            resp_value_s  = rd_data;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_status_s = ST_OK;
               resp_value_s  = '0;
            end else begin
               resp_value_s  = resp_value_r;
            end
         end
         default: begin
            resp_status_s = ST_OK;
         end
      endcase
   end

   // request capture, slot metadata and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_op_r      <= OP_GET;
         cap_key_r     <= '0;
         cap_value_r   <= '0;
         tgt_idx_r     <= '0;
         valid_r       <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            key_r[i] <= '0;
         end
         req_ready_r   <= 1'b0;
         resp_valid_r  <= 1'b0;
         resp_status_r <= ST_OK;
         resp_value_r  <= '0;
         write_op_r    <= '0;
         select_op_r   <= '0;
         wr_data_r     <= '0;
         occupancy_r   <= '0;
      end else begin
         if (accept_s) begin
            cap_op_r    <= op_e'(req_op);
            cap_key_r   <= req_key;
            cap_value_r <= req_value;
         end
         if (state_r == S_LOOKUP) begin
            tgt_idx_r <= tgt_idx_s;
         end
         if (state_r == S_WRITE) begin
            key_r[tgt_idx_r] <= cap_key_r;
         end
         valid_r       <= valid_s;
         occupancy_r   <= popcount(valid_s);
         req_ready_r   <= (state_s == S_IDLE);
         resp_valid_r  <= (state_s == S_RESP);
         resp_status_r <= resp_status_s;
         resp_value_r  <= resp_value_s;
         write_op_r    <= write_op_s;
         select_op_r   <= select_op_s;
         wr_data_r     <= wr_data_s;
      end
   end

   assign req_ready   = req_ready_r;
   assign resp_valid  = resp_valid_r;
   assign resp_status = resp_status_r;
   assign resp_value  = resp_value_r;
   assign write_op    = write_op_r;
   assign select_op   = select_op_r;
   assign wr_data     = wr_data_r;
   assign occupancy   = occupancy_r;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a behavioural model of the eight
// external register arrays on the shared read/write bus.
module tb_memory_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_key;
   logic [31:0] req_value;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_status;
   logic [31:0] resp_value;
   logic [7:0]  write_op;
   logic [7:0]  select_op;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [3:0]  occupancy;

   int ncmp = 0;
   int nfail = 0;
   int mon_viol = 0;
   logic [31:0] mem [8];

   always #5 clk = ~clk;

   memory_controller #(.NUM_ENTRIES(8), .KEY_WIDTH(16), .VALUE_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_key     (req_key),
      .req_value   (req_value),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_status (resp_status),
      .resp_value  (resp_value),
      .write_op    (write_op),
      .select_op   (select_op),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .occupancy   (occupancy)
   );

   // external register arrays: write on strobe, drive the bus when selected
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (write_op[i]) mem[i] <= wr_data;
      end
   end

   always_comb begin
      rd_data = 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (select_op[i]) rd_data = rd_data | mem[i];
      end
   end

   // strobe invariants sampled every cycle out of reset
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (((write_op & (write_op - 8'd1)) != 8'd0) || ((select_op & (select_op - 8'd1)) != 8'd0) ||
             ((write_op != 8'd0) && (select_op != 8'd0)) || ((write_op == 8'd0) && (wr_data != 32'd0))) begin
            mon_viol++;
            $display("strobe violation at %0t: write_op=%h select_op=%h wr_data=%h", $time, write_op, select_op, wr_data);
         end
      end
   end

   // one transaction; latency counts the LOOKUP cycle after the accept edge as cycle 1
   task automatic issue(input logic [1:0] op, input logic [15:0] key, input logic [31:0] val,
                        output logic [1:0] st, output logic [31:0] v, output int lat,
                        output logic [7:0] wr_seen, output logic [7:0] sel_seen, output int wr_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; wr_seen = 8'h0; sel_seen = 8'h0; wr_cyc = 0;
      while (!resp_valid && lat < 10) begin
         wr_seen = wr_seen | write_op;
         sel_seen = sel_seen | select_op;
         if (write_op != 8'h0) wr_cyc++;
         @(negedge clk);
         lat++;
      end
      st = resp_status;
      v = resp_value;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_key = 16'h0; req_value = 32'h0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      ncmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin nfail++; $display("FAIL reset_handshake: req_ready=%b resp_valid=%b, want 0/0", req_ready, resp_valid); end
      ncmp++; if (write_op !== 8'h0 || select_op !== 8'h0 || wr_data !== 32'h0) begin nfail++; $display("FAIL reset_strobes: write_op=%h select_op=%h wr_data=%h, want 0", write_op, select_op, wr_data); end
      ncmp++; if (resp_status !== 2'd0 || resp_value !== 32'h0 || occupancy !== 4'd0) begin nfail++; $display("FAIL reset_resp: status=%0d value=%h occ=%0d, want 0/0/0", resp_status, resp_value, occupancy); end
      rst = 1'b1;
      @(negedge clk);
      ncmp++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_release_ready: got %b, want 1", req_ready); end
   endtask

   task automatic test_put_get();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      issue(2'd1, 16'h0012, 32'hDEADBEEF, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || v !== 32'h0) begin nfail++; $display("FAIL put_first_resp: status=%0d value=%h, want 0/0", st, v); end
      ncmp++; if (lat !== 3) begin nfail++; $display("FAIL put_first_latency: got %0d, want 3", lat); end
      ncmp++; if (ws !== 8'h01 || wc !== 1 || ss !== 8'h00) begin nfail++; $display("FAIL put_first_strobe: write=%h cycles=%0d select=%h, want 01/1/00", ws, wc, ss); end
      ncmp++; if (occupancy !== 4'd1) begin nfail++; $display("FAIL put_first_occ: got %0d, want 1", occupancy); end
      issue(2'd0, 16'h0012, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || v !== 32'hDEADBEEF) begin nfail++; $display("FAIL get_first_resp: status=%0d value=%h, want 0/deadbeef", st, v); end
      ncmp++; if (lat !== 3 || ss !== 8'h01 || ws !== 8'h00) begin nfail++; $display("FAIL get_first_strobe: lat=%0d select=%h write=%h, want 3/01/00", lat, ss, ws); end
   endtask

   task automatic test_resp_hold();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      logic [1:0] st0; logic [31:0] v0; int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_op = 2'd0; req_key = 16'h0012;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 10) begin @(negedge clk); n++; end
      st0 = resp_status; v0 = resp_value;
      ncmp++; if (st0 !== 2'd0 || v0 !== 32'hDEADBEEF) begin nfail++; $display("FAIL hold_first: status=%0d value=%h, want 0/deadbeef", st0, v0); end
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            req_valid = 1'b1; req_op = 2'd1; req_key = 16'h0888; req_value = 32'h00000888;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         ncmp++; if (resp_valid !== 1'b1 || resp_status !== st0 || resp_value !== v0 || req_ready !== 1'b0) begin
            nfail++; $display("FAIL hold_stable[%0d]: valid=%b status=%0d value=%h ready=%b, want 1/%0d/%h/0", c, resp_valid, resp_status, resp_value, req_ready, st0, v0);
         end
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      ncmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin nfail++; $display("FAIL hold_release: valid=%b ready=%b, want 0/1", resp_valid, req_ready); end
      issue(2'd0, 16'h0888, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd1 || occupancy !== 4'd1) begin nfail++; $display("FAIL hold_ignored_req: status=%0d occ=%0d, want 1/1", st, occupancy); end
   endtask

   task automatic test_full();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      logic [7:0] exp_ws;
      for (int i = 1; i < 8; i++) begin
         exp_ws = 8'h01 << i;
         issue(2'd1, 16'h0100 + 16'(i), 32'hA0000000 + 32'(i), st, v, lat, ws, ss, wc);
         ncmp++; if (st !== 2'd0 || ws !== exp_ws || lat !== 3) begin nfail++; $display("FAIL fill[%0d]: status=%0d write=%h lat=%0d, want 0/%h/3", i, st, ws, lat, exp_ws); end
      end
      ncmp++; if (occupancy !== 4'd8) begin nfail++; $display("FAIL fill_occ: got %0d, want 8", occupancy); end
      issue(2'd1, 16'h0999, 32'h99999999, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd2 || v !== 32'h0 || lat !== 2) begin nfail++; $display("FAIL full_resp: status=%0d value=%h lat=%0d, want 2/0/2", st, v, lat); end
      ncmp++; if (ws !== 8'h00 || ss !== 8'h00 || occupancy !== 4'd8) begin nfail++; $display("FAIL full_nostrobe: write=%h select=%h occ=%0d, want 00/00/8", ws, ss, occupancy); end
      issue(2'd1, 16'h0103, 32'h12345678, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || ws !== 8'h08 || lat !== 3 || occupancy !== 4'd8) begin nfail++; $display("FAIL overwrite: status=%0d write=%h lat=%0d occ=%0d, want 0/08/3/8", st, ws, lat, occupancy); end
      issue(2'd0, 16'h0103, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || v !== 32'h12345678 || ss !== 8'h08) begin nfail++; $display("FAIL overwrite_get: status=%0d value=%h select=%h, want 0/12345678/08", st, v, ss); end
   endtask

   task automatic test_del();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      issue(2'd2, 16'h0012, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || lat !== 2 || ws !== 8'h00 || ss !== 8'h00) begin nfail++; $display("FAIL del_hit: status=%0d lat=%0d write=%h select=%h, want 0/2/00/00", st, lat, ws, ss); end
      ncmp++; if (occupancy !== 4'd7) begin nfail++; $display("FAIL del_occ: got %0d, want 7", occupancy); end
      issue(2'd2, 16'h5555, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd1 || lat !== 2 || occupancy !== 4'd7) begin nfail++; $display("FAIL del_miss: status=%0d lat=%0d occ=%0d, want 1/2/7", st, lat, occupancy); end
      issue(2'd0, 16'h0012, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd1 || v !== 32'h0 || lat !== 2 || ss !== 8'h00) begin nfail++; $display("FAIL get_after_del: status=%0d value=%h lat=%0d select=%h, want 1/0/2/00", st, v, lat, ss); end
      issue(2'd1, 16'h0777, 32'h00000777, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || ws !== 8'h01 || occupancy !== 4'd8) begin nfail++; $display("FAIL put_reuse_slot: status=%0d write=%h occ=%0d, want 0/01/8", st, ws, occupancy); end
   endtask

   task automatic test_reserved();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      issue(2'd3, 16'h0103, 32'hFFFFFFFF, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd3 || v !== 32'h0 || lat !== 2) begin nfail++; $display("FAIL reserved_resp: status=%0d value=%h lat=%0d, want 3/0/2", st, v, lat); end
      ncmp++; if (ws !== 8'h00 || ss !== 8'h00 || occupancy !== 4'd8) begin nfail++; $display("FAIL reserved_nostrobe: write=%h select=%h occ=%0d, want 00/00/8", ws, ss, occupancy); end
   endtask

   task automatic test_reset_mid_write();
      logic [1:0] st; logic [31:0] v; int lat; logic [7:0] ws; logic [7:0] ss; int wc;
      int n; int seen;
      issue(2'd2, 16'h0777, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd0 || occupancy !== 4'd7) begin nfail++; $display("FAIL pre_abort_del: status=%0d occ=%0d, want 0/7", st, occupancy); end
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_op = 2'd1; req_key = 16'h0ABC; req_value = 32'h00000ABC;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (write_op == 8'h0 && n < 10) begin @(negedge clk); n++; end
      ncmp++; if (write_op !== 8'h01) begin nfail++; $display("FAIL abort_reach_write: write_op=%h, want 01", write_op); end
      rst = 1'b0;
      @(negedge clk);
      ncmp++; if (resp_valid !== 1'b0 || occupancy !== 4'd0 || write_op !== 8'h0 || req_ready !== 1'b0) begin
         nfail++; $display("FAIL abort_state: valid=%b occ=%0d write=%h ready=%b, want 0/0/00/0", resp_valid, occupancy, write_op, req_ready);
      end
      rst = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen++;
      end
      ncmp++; if (seen !== 0) begin nfail++; $display("FAIL abort_no_resp: resp_valid high in %0d cycles, want 0", seen); end
      issue(2'd0, 16'h0ABC, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd1 || v !== 32'h0 || lat !== 2) begin nfail++; $display("FAIL abort_get_aborted_key: status=%0d value=%h lat=%0d, want 1/0/2", st, v, lat); end
      issue(2'd0, 16'h0103, 32'h0, st, v, lat, ws, ss, wc);
      ncmp++; if (st !== 2'd1 || occupancy !== 4'd0) begin nfail++; $display("FAIL abort_get_old_key: status=%0d occ=%0d, want 1/0", st, occupancy); end
   endtask

   task automatic test_invariants();
      ncmp++; if (mon_viol !== 0) begin nfail++; $display("FAIL strobe_invariants: got %0d violating cycles, want 0", mon_viol); end
   endtask

   initial begin
      test_reset();
      test_put_get();
      test_resp_hold();
      test_full();
      test_del();
      test_reserved();
      test_reset_mid_write();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
